// File: rtl/axilite_cfg_master_if.sv
`default_nettype none
// ============================================================================
// axilite_cfg_master_if : AXI-Lite AW/W/AR/R channel bundle (no B channel)
// Revision: 1.0
// ============================================================================
interface axilite_cfg_master_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/axilite_cfg_master.sv
`default_nettype none
// ============================================================================
// axilite_cfg_master : single-command AXI-Lite initiator with per-transaction watchdog
// Revision: 1.0
// ============================================================================
module axilite_cfg_master #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 64
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [pDATA_WIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [pDATA_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  axilite_cfg_master_if.master   axi
);

  localparam int CNT_W = ($clog2(pTIMEOUT) > 8) ? $clog2(pTIMEOUT) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(pTIMEOUT - 2);

  typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, RESP} state_e;

  state_e                 state_q,     state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   awvalid_q,   awvalid_d;
  logic                   wvalid_q,    wvalid_d;
  logic                   arvalid_q,   arvalid_d;
  logic                   rready_q,    rready_d;
  logic [pADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [pDATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [pDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic                   expire;

  // >= rather than == : a read whose AR handshake lands on the last edge
  // enters RD_D already expired and gets exactly one rready cycle.
  assign expire = (cnt_q >= TO_LAST);

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          cnt_d       = '0;
          if (cmd_write) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_A;
            arvalid_d = 1'b1;
          end
        end
      end

      WR: begin
        awvalid_d = awvalid_q & ~axi.awready;
        wvalid_d  = wvalid_q & ~axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end else if (expire) begin
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RD_A: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_D;
          cnt_d     = cnt_q + 1'b1;
        end else if (expire) begin
          arvalid_d   = 1'b0;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RD_D: begin
        if (axi.rvalid) begin
          rready_d    = 1'b0;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = axi.rdata;
          rsp_err_d   = 1'b0;
        end else if (expire) begin
          rready_d    = 1'b0;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = addr_q;
  assign axi.rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axilite_cfg_master.sv
`default_nettype none
// ============================================================================
// tb_axilite_cfg_master : directed + randomized bench with a delay-based reference model
// Revision: 1.0
// ============================================================================
module tb_axilite_cfg_master;

  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int TO     = 8;
  localparam int BUDGET = 40;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  int vectors;
  int miscompares;
  bit txn_done;
  int aw_n, w_n, ar_n, rr_n;

  axilite_cfg_master_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) axi ();

  axilite_cfg_master #(
    .pADDR_WIDTH(AW),
    .pDATA_WIDTH(DW),
    .pTIMEOUT   (TO)
  ) dut (
    .axis_clk  (clk),
    .axis_rst_n(rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .axi       (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Delays count valid cycles before the slave raises ready (R delay counts rready cycles).
  task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int daw, input int dw, input int dar, input int dr,
                         input logic [DW-1:0] rv, input int hold);
    bit            exp_to;
    logic [DW-1:0] exp_rd;
    int            e_aw, e_w, e_ar, e_rr, win;
    // Reference: a phase gets at most TO-1 valid cycles from the start of the transaction.
    if (wr) begin
      e_aw = imin(daw + 1, TO - 1);
      e_w  = imin(dw + 1, TO - 1);
      e_ar = 0;
      e_rr = 0;
      exp_to = (imax(daw, dw) > TO - 2);
    end else begin
      e_aw = 0;
      e_w  = 0;
      e_ar = imin(dar + 1, TO - 1);
      if (dar > TO - 2) begin
        e_rr = 0;
        exp_to = 1'b1;
      end else begin
        win    = imax(1, TO - 2 - dar);
        e_rr   = imin(dr + 1, win);
        exp_to = (dr + 1 > win);
      end
    end
    exp_rd = (wr || exp_to) ? '0 : rv;

    txn_done = 1'b0;
    fork
      begin
        int k;
        k = 0;
        while (!cmd_ready && k < BUDGET) begin
          @(negedge clk);
          k++;
        end
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        check("cmd_ready_drop", 64'(cmd_ready), 64'd0);
        k = 0;
        while (!rsp_valid && k < BUDGET) begin
          @(negedge clk);
          k++;
        end
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        txn_done = 1'b1;
        check("rsp_err", 64'(rsp_err), 64'(exp_to));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        repeat (hold) begin
          @(negedge clk);
          check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
          check("hold_rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
          check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_clear", 64'(rsp_valid), 64'd0);
        check("cmd_ready_back", 64'(cmd_ready), 64'd1);
      end
      begin
        int n;
        n = 0;
        axi.awready = 1'b0;
        while (!txn_done) begin
          @(negedge clk);
          if (axi.awvalid) begin
            check("awaddr", 64'(axi.awaddr), 64'(addr));
            axi.awready = (n == daw);
            n++;
          end else begin
            axi.awready = 1'b0;
          end
        end
        axi.awready = 1'b0;
        aw_n = n;
      end
      begin
        int n;
        n = 0;
        axi.wready = 1'b0;
        while (!txn_done) begin
          @(negedge clk);
          if (axi.wvalid) begin
            check("wdata", 64'(axi.wdata), 64'(wd));
            axi.wready = (n == dw);
            n++;
          end else begin
            axi.wready = 1'b0;
          end
        end
        axi.wready = 1'b0;
        w_n = n;
      end
      begin
        int na, nr;
        na = 0;
        nr = 0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        while (!txn_done) begin
          @(negedge clk);
          axi.arready = 1'b0;
          axi.rvalid  = 1'b0;
          axi.rdata   = $urandom;
          if (axi.arvalid) begin
            check("araddr", 64'(axi.araddr), 64'(addr));
            axi.arready = (na == dar);
            axi.rvalid  = 1'($urandom_range(0, 1));
            na++;
          end
          if (axi.rready) begin
            axi.rvalid = (nr == dr);
            if (nr == dr) axi.rdata = rv;
            nr++;
          end
        end
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        ar_n = na;
        rr_n = nr;
      end
    join
    check("awvalid_cycles", 64'(aw_n), 64'(e_aw));
    check("wvalid_cycles", 64'(w_n), 64'(e_w));
    check("arvalid_cycles", 64'(ar_n), 64'(e_ar));
    check("rready_cycles", 64'(rr_n), 64'(e_rr));
  endtask

  function automatic int rnd_delay();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    rsp_ready   = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;

    #2;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_awvalid", 64'(axi.awvalid), 64'd0);
    check("rst_wvalid", 64'(axi.wvalid), 64'd0);
    check("rst_arvalid", 64'(axi.arvalid), 64'd0);
    check("rst_rready", 64'(axi.rready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("cmd_ready_pre", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("cmd_ready_post_rst", 64'(cmd_ready), 64'd1);

    // Directed scenarios
    run_cmd(1'b1, 12'h020, 32'h0000_0005, 0, 0, 0, 0, '0, 0);
    run_cmd(1'b1, 12'h024, 32'hDEAD_BEEF, 1, 4, 0, 0, '0, 0);
    run_cmd(1'b0, 12'h000, '0, 0, 0, 2, 3, 32'h0000_0004, 0);
    run_cmd(1'b0, 12'h010, '0, 0, 0, 100, 0, 32'h1234_5678, 0);
    run_cmd(1'b0, 12'h000, '0, 0, 0, 0, 0, 32'h0000_0002, 0);
    run_cmd(1'b1, 12'h028, 32'hCAFE_F00D, 100, 2, 0, 0, '0, 0);
    run_cmd(1'b0, 12'h004, '0, 0, 0, 6, 0, 32'h0BAD_0001, 0);
    run_cmd(1'b0, 12'h008, '0, 0, 0, 0, 5, 32'h0BAD_0002, 0);
    run_cmd(1'b0, 12'h00C, '0, 0, 0, 1, 0, 32'hA5A5_5A5A, 5);

    // Reset pulse in the middle of a write
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'h030;
    cmd_wdata = 32'h7777_1111;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_wr_awvalid", 64'(axi.awvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_awvalid", 64'(axi.awvalid), 64'd0);
    check("arst_wvalid", 64'(axi.wvalid), 64'd0);
    check("arst_awaddr", 64'(axi.awaddr), 64'd0);
    check("arst_wdata", 64'(axi.wdata), 64'd0);
    check("arst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("arst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("post_rst_awvalid", 64'(axi.awvalid), 64'd0);
    end
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Back-to-back tap loads then a status read
    for (int i = 0; i < 11; i++) begin
      run_cmd(1'b1, AW'(12'h040 + 4 * i), $urandom, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), 0, 0, '0, 0);
    end
    run_cmd(1'b0, 12'h000, '0, 0, 0, 0, 1, 32'h0000_0006, 0);

    // Randomized commands, including occasional timeouts
    for (int i = 0; i < 30; i++) begin
      run_cmd(1'($urandom), AW'($urandom) & 12'hFFC, $urandom, rnd_delay(), rnd_delay(),
              rnd_delay(), rnd_delay(), $urandom, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axilite_cfg_master.md
Name: axilite_cfg_master

Overview:
- AXI-Lite initiator that turns single-word register commands into AXI-Lite write or read transactions toward the fir configuration slave.
- Used by the host-side sequencer to load taps, write ap_start and poll ap_done/ap_idle. A host-side bench driver can stand in for it.
- The slave side has no B channel, so a write completes once both the AW and W handshakes are done.
- A per-transaction watchdog reports hung transactions.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, AXI-Lite data width
- pTIMEOUT, 64, cycles allowed per transaction before abort (at least 2)

Ports:
- axis_clk  in  1  clock; everything is rising-edge
- axis_rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  pADDR_WIDTH  register address
- cmd_wdata  in  pDATA_WIDTH  write data
- rsp_valid  out  1  transaction finished
- rsp_ready  in  1  response consumed
- rsp_rdata  out  pDATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  transaction aborted by timeout
- awvalid  out  1  AW channel valid
- awready  in  1  AW channel ready
- awaddr  out  pADDR_WIDTH  AW channel address
- wvalid  out  1  W channel valid
- wready  in  1  W channel ready
- wdata  out  pDATA_WIDTH  W channel data
- arvalid  out  1  AR channel valid
- arready  in  1  AR channel ready
- araddr  out  pADDR_WIDTH  AR channel address
- rvalid  in  1  R channel valid
- rready  out  1  R channel ready
- rdata  in  pDATA_WIDTH  R channel data

Behaviour:
- Reset (asynchronous, while axis_rst_n = 0):
  - every output is 0; cmd_ready becomes 1 on the first clock after release;
  - state returns to IDLE and all address/data/counter registers clear;
  - reset in the middle of a transaction drops all valids immediately and returns no response.
- States: IDLE, WR, RD_A, RD_D, RESP.
- IDLE:
  - cmd_ready = 1 (registered and asserted only in IDLE).
  - On cmd_valid & cmd_ready, latch cmd_addr, cmd_wdata and cmd_write.
  - Next cycle: write → WR with awvalid = wvalid = 1; read → RD_A with arvalid = 1.
  - cmd_ready drops in the same edge the command is accepted.
- WR:
  - awvalid and wvalid assert together.
  - Each channel deasserts on the edge after its own handshake (valid & ready); the two channels complete independently and in either order.
  - awaddr and wdata stay stable while the corresponding valid is high.
  - When both handshakes have occurred, including the same cycle, go to RESP with rsp_rdata = 0 and rsp_err = 0.
- RD_A:
  - arvalid held with araddr stable until the arready handshake.
  - Then go to RD_D with rready = 1 and arvalid = 0.
- RD_D:
  - rready held until rvalid; capture rdata on the handshake edge.
  - Go to RESP with rsp_rdata = captured value and rready = 0.
  - rvalid arriving while still in RD_A is ignored, because rready is 0 there.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable until rsp_valid & rsp_ready.
  - Then return to IDLE; cmd_ready = 1 on the next cycle.
- Minimum cost per command: one cycle for the command handshake, then at least one cycle per address/data phase.
- Watchdog:
  - An 8-bit or wider counter clears on entry to WR or RD_A.
  - It increments every cycle in WR, RD_A or RD_D and does not clear between RD_A and RD_D.
  - When it reaches pTIMEOUT-1 with the transaction incomplete: deassert all valids and rready, go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - A handshake completing on the same edge as the timeout wins: normal completion, rsp_err = 0.
- Protocol rules:
  - Never more than one outstanding transaction.
  - awvalid/wvalid/arvalid never drop before their handshake except by timeout or reset.
  - Valids never depend combinationally on ready inputs; all AXI outputs are registered.

Test Plan:
- Write, slave ready immediately: cmd addr 0x020, wdata 0x0000_0005, awready = wready = 1 → awvalid and wvalid high 1 cycle each, awaddr = 0x020, wdata = 0x5; rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- Skewed write: awready 1 cycle after valid, wready 4 cycles after valid → awvalid drops first, wvalid held 4 cycles; rsp_valid only after both handshakes; data 0xDEAD_BEEF stable throughout.
- Read with wait states: cmd read addr 0x000; arready after 2 cycles; rvalid with rdata 0x0000_0004 3 cycles later → rready high exactly until the handshake; rsp_rdata = 0x4, rsp_err = 0.
- Timeout: pTIMEOUT = 8, read with arready tied 0 → arvalid drops after 7 cycles; rsp_err = 1, rsp_rdata = 0; the next command is accepted normally.
- Back-pressure and reset: rsp_ready held 0 for 5 cycles → rsp_valid and values stable, cmd_ready = 0. Pulsing axis_rst_n low mid-WR → all outputs 0 asynchronously; no rsp_valid afterwards.
- Back-to-back: 11 tap writes to 0x040..0x068 followed by a read of 0x000 → 12 responses in order; each write's address and data match its command.
